instr_fetch_unit: RTL and testbench

//  Fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC and issues word reads to instruction memory.

---
 rtl/instr_fetch_unit_if.sv | 34 +++
 rtl/instr_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response bus
//
// Purpose: groups the word-read handshake between the fetch unit and instruction memory.
// Signals:
//   req    fetch -> mem  read request
//   addr   fetch -> mem  word address (addr[1:0] == 2'b00)
//   gnt    mem -> fetch  request accepted this cycle (meaningful only while req=1)
//   rvalid mem -> fetch  read data valid, at least one cycle after gnt
//   rdata  mem -> fetch  read data
// Modports: master (fetch unit side), slave (memory side).

interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage with prefetch FIFO and EX redirect
//
// Purpose: owns the fetch PC, issues one outstanding word read at a time to
// instruction memory, buffers returned words with their PC in a prefetch FIFO and
// presents the FIFO head to the IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN enables the perf_fetch/perf_empty
// counters; when undefined both ports are tied to zero.
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch entries, power of 2, >= 2
// Ports:
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   EN_n          IF/ID enable, active low; FIFO head consumed when low and valid
//   PCSrcE        redirect request from EX
//   PCTargetE     redirect target (low two bits ignored)
//   imem          instruction memory bus (master modport)
//   PCF           PC of FIFO head, 0 when empty
//   PCPlus4F      PCF + 4
//   instr_RD      FIFO head instruction, NOP when empty
//   InstValidF    FIFO non-empty
//   perf_fetch    granted-request count
//   perf_empty    cycles with EN_n=0 and FIFO empty

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 EN_n,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  instr_fetch_unit_if.master   imem,
  output logic [31:0]          PCF,
  output logic [31:0]          PCPlus4F,
  output logic [31:0]          instr_RD,
  output logic                 InstValidF,
  output logic [31:0]          perf_fetch,
  output logic [31:0]          perf_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      fetch_pc_q;
  logic [31:0]      req_addr_q;   // address of the outstanding read
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];

  logic req_c, grant, push, pop, valid;

  assign valid = (count_q != '0);
  assign grant = req_c && imem.gnt;
  // Redirect wins over any same-cycle pop.
  assign pop   = !EN_n && valid && !PCSrcE;

  // FSM next state and request generation
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // Request is gated by reset_n so the bus is quiet while held in reset.
        req_c = reset_n && (count_q < DEPTH_C);
        if (req_c && imem.gnt) begin
          state_d = PCSrcE ? STALE : BUSY;
        end
      end
      BUSY: begin
        if (imem.rvalid) begin
          push    = !PCSrcE;
          state_d = IDLE;
        end else if (PCSrcE) begin
          state_d = STALE;
        end
      end
      STALE: begin
        if (imem.rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch PC and outstanding-request address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      if (grant) begin
        req_addr_q <= fetch_pc_q;
      end
      if (PCSrcE) begin
        fetch_pc_q <= PCTargetE & ~32'h3;
      end else if (grant) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
    end
  end

  assign imem.req  = req_c;
  assign imem.addr = fetch_pc_q;

  // FIFO pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (PCSrcE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_addr_q;
      instr_mem[wr_ptr_q] <= imem.rdata;
    end
  end

  assign InstValidF = valid;
  assign PCF        = valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign instr_RD   = valid ? instr_mem[rd_ptr_q] : NOP;
  assign PCPlus4F   = PCF + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_empty_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= '0;
      perf_empty_q <= '0;
    end else begin
      if (grant) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (!EN_n && !valid) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_empty = perf_empty_q;
`else
  assign perf_fetch = 32'h0;
  assign perf_empty = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        EN_n;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF, PCPlus4F, instr_RD, perf_fetch, perf_empty;
  logic        InstValidF;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .EN_n       (EN_n),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem       (imem_bus),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .instr_RD   (instr_RD),
    .InstValidF (InstValidF),
    .perf_fetch (perf_fetch),
    .perf_empty (perf_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-order stream of {pc, instr} fetched since the last redirect.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fetch;     // next address to request
  bit          m_out;       // a read is outstanding at the memory
  bit          m_live;      // outstanding read will be kept (no redirect since it was granted)
  logic [31:0] m_paddr;
  int          mem_cnt;     // cycles until rvalid for the outstanding read
  int          m_lat = 1;   // latency used for the next grant
  logic [31:0] m_pf, m_pe;

  function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_fetch = RESET_PC;
    m_out   = 1'b0;
    m_live  = 1'b0;
    m_paddr = RESET_PC;
    mem_cnt = 0;
    m_pf    = 0;
    m_pe    = 0;
  endtask

  task automatic compare_outputs();
    bit req_m;
    req_m = !m_out && (q.size() < DEPTH);
    check("valid", {31'b0, InstValidF}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      check("pcf",   PCF,      q[0].pc);
      check("pcp4",  PCPlus4F, q[0].pc + 32'd4);
      check("instr", instr_RD, q[0].ins);
    end else begin
      check("pcf_empty",   PCF,      32'h0);
      check("pcp4_empty",  PCPlus4F, 32'h4);
      check("instr_empty", instr_RD, NOP);
    end
    check("req",  {31'b0, imem_bus.req}, {31'b0, req_m});
    check("addr", imem_bus.addr, m_fetch);
    check("perf_fetch", perf_fetch, exp_perf(m_pf));
    check("perf_empty", perf_empty, exp_perf(m_pe));
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model, take the edge.
  task automatic step(input bit en_i, input bit redir, input logic [31:0] tgt, input bit gnt_i);
    bit          rv, req_m, grant, pop;
    logic [31:0] rd;
    @(negedge clk);
    compare_outputs();
    req_m = !m_out && (q.size() < DEPTH);
    rv    = m_out && (mem_cnt == 0);
    rd    = $urandom;
    EN_n            = en_i;
    PCSrcE          = redir;
    PCTargetE       = tgt;
    imem_bus.gnt    = gnt_i;
    imem_bus.rvalid = rv;
    imem_bus.rdata  = rd;
    grant = req_m && gnt_i;
    pop   = !en_i && (q.size() != 0) && !redir;
    if (!en_i && q.size() == 0) m_pe++;
    if (grant) m_pf++;
    if (pop) void'(q.pop_front());
    if (rv) begin
      m_out = 1'b0;
      if (m_live && !redir) q.push_back('{pc: m_paddr, ins: rd});
    end else if (m_out && mem_cnt > 0) begin
      mem_cnt--;
    end
    if (grant) begin
      m_out   = 1'b1;
      m_live  = !redir;
      m_paddr = m_fetch;
      m_fetch = m_fetch + 32'd4;
      mem_cnt = m_lat - 1;
    end
    if (redir) begin
      q.delete();
      m_live  = 1'b0;
      m_fetch = tgt & ~32'h3;
    end
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n         = 1'b0;
    EN_n            = 1'b1;
    PCSrcE          = 1'b0;
    PCTargetE       = 32'h0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;
    model_reset();
    #1;
    check("rst_req",   {31'b0, imem_bus.req}, 32'h0);
    check("rst_addr",  imem_bus.addr, RESET_PC);
    check("rst_pcf",   PCF, 32'h0);
    check("rst_pcp4",  PCPlus4F, 32'h4);
    check("rst_instr", instr_RD, NOP);
    check("rst_valid", {31'b0, InstValidF}, 32'h0);
    check("rst_pf",    perf_fetch, 32'h0);
    check("rst_pe",    perf_empty, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    apply_reset();

    // Grant withheld for 5 cycles with EN_n=0
    m_lat = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("pe_after5", perf_empty, exp_perf(32'd5));
    check("pf_after5", perf_fetch, 32'h0);

    // Streaming with 1-cycle memory
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall until full, then drain
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("full_req", {31'b0, imem_bus.req}, 32'h0);
    check("full_cnt", q.size(), DEPTH);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while BUSY with slow memory
    m_lat = 3;
    n = 0;
    while (!m_out && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    if (!m_out) check("timeout_busy", 32'h0, 32'h1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    #1;
    check("redir_busy_addr", imem_bus.addr, 32'h100);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with rvalid and a pop; unaligned target
    m_lat = 1;
    n = 0;
    while (!(q.size() == 1 && m_out && mem_cnt == 0) && n < 20) begin
      step(1'b1, 1'b0, 32'h0, 1'b1); n++;
    end
    if (!(q.size() == 1 && m_out && mem_cnt == 0)) check("timeout_rvpop", 32'h0, 32'h1);
    step(1'b0, 1'b1, 32'h203, 1'b1);
    #1;
    check("redir_pop_addr",  imem_bus.addr, 32'h200);
    check("redir_pop_valid", {31'b0, InstValidF}, 32'h0);
    check("redir_pop_req",   {31'b0, imem_bus.req}, 32'h1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 3-cycle memory with sporadic grants
    m_lat = 3;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0, $urandom_range(0, 1) == 1);

    // Wrap of fetch_pc past the top of the address space
    m_lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while a read is outstanding
    m_lat = 4;
    n = 0;
    while (!m_out && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      m_lat = $urandom_range(1, 4);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=%08h exp=%08h", 32'h0, 32'h1);
    $fatal(1, "watchdog");
  end

endmodule
